fetch_pc: RTL and testbench
===========================

// Module: fetch_pc
// PURPOSE
//  Fetch-stage PC generator sitting directly upstream of the branch predictor.
//  Fetches one instruction per memory handshake and predecodes it for B-type / JAL.
//  Drives predictor insert/query and uses the returned prediction to pick the next PC.
//  Hands {inst, pc, prediction} to decode; the ROB redirects on mispredict.
// PARAMETERS
//  ADDR_W    32  PC / address width
//  INST_W    32  instruction width (RV32)
//  RESET_PC  0   PC loaded at reset
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       synchronous reset, ACTIVE-LOW
//  rdy              in   1       global enable; 0 freezes all state
//  mem_req          out  1       fetch request, held until mem_ack
//  mem_addr         out  ADDR_W  fetch address; stable while mem_req=1
//  mem_ack          in   1       one-cycle pulse; mem_inst valid this cycle
//  mem_inst         in   INST_W  fetched instruction
//  pred_insert_en   out  1       predictor history insert (one cycle per branch)
//  pred_mux         out  1       predictor port select; tied 0 (single issue)
//  pred_pc1         out  ADDR_W  PC of branch being predicted
//  pred_pc2         out  ADDR_W  equals pred_pc1
//  pred_taken       in   1       predictor output (predict1), combinational
//  rob_redirect     in   1       mispredict flush
//  rob_target       in   ADDR_W  correct PC on flush
//  dec_valid        out  1       instruction available to decode
//  dec_ready        in   1       decode accepts when dec_valid & dec_ready
//  dec_inst         out  INST_W  instruction
//  dec_pc           out  ADDR_W  its PC
//  dec_pred_taken   out  1       1 = taken predicted (JAL always 1)
//  dec_pred_target  out  ADDR_W  predicted next PC
// BEHAVIOUR
//  Reset (rst=0 at edge): pc<=RESET_PC, state<=REQ. mem_req, dec_valid, pred_insert_en
//   and dec_* outputs are 0.
//  FSM states: REQ, WAIT, HOLD, DRAIN.
//   REQ:   mem_req=1, mem_addr=pc; next state WAIT.
//   WAIT:  mem_req=1, mem_addr=pc. On mem_ack: latch inst, pc, next_pc, taken
//          into the dec_* registers; next state HOLD.
//   HOLD:  dec_valid=1, mem_req=0. On dec_valid&dec_ready: pc<=dec_pred_target;
//          next state REQ.
//   DRAIN: mem_req=1 on the stale address. On mem_ack: discard; next state REQ.
//  Predecode of mem_inst, opcode = inst[6:0]:
//   1100011 (B): immB = {{20{i[31]}},i[7],i[30:25],i[11:8],1'b0};
//                next_pc = pred_taken ? pc+immB : pc+4.
//   1101111 (JAL): immJ = {{12{i[31]}},i[19:12],i[20],i[30:21],1'b0};
//                next_pc = pc+immJ; taken=1.
//   Other opcodes, including JALR: next_pc = pc+4; taken=0.
//  Address arithmetic is modulo 2^ADDR_W; wrap is silent.
//  pred_insert_en is combinational: 1 iff state=WAIT & mem_ack & B-type & rdy & !rob_redirect.
//   Exactly one cycle per fetched branch. pred_pc1=pc in that cycle.
//   pred_taken is sampled in that same cycle.
//  rob_redirect has highest priority, in any state:
//   pc<=rob_target; dec_valid<=0; pred_insert_en=0.
//   Next state: DRAIN if in WAIT or REQ without mem_ack this cycle, else REQ.
//   Redirect coinciding with mem_ack: the data is discarded; next state REQ.
//   Redirect during DRAIN: update pc and stay in DRAIN.
//  rdy=0: no state or register changes; outputs hold; pred_insert_en=0.
//   A mem_ack arriving while rdy=0 is ignored.
//  Reset mid-fetch: an outstanding mem_ack after reset is ignored.
//   In REQ/WAIT after reset the fetch restarts at RESET_PC; the memory side must
//   tolerate this.
//  Throughput: at most one instruction per 3 cycles. No buffering beyond HOLD.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> mem_req=0, dec_valid=0.
//    Release -> mem_req=1, mem_addr=0x0 next cycle.
//  2 Sequential: ack 0x00000013 @0x0 -> dec_pc=0, dec_pred_target=4, pred_insert_en
//    never 1. After handshake, mem_addr=0x4.
//  3 Branch 0x00000463 (beq +8) @0x10:
//    pred_taken=1 -> insert_en 1 for 1 cycle, pred_pc1=0x10, next addr 0x18.
//    pred_taken=0 -> next addr 0x14.
//  4 JAL 0x0080006F @0x20 -> dec_pred_taken=1, target 0x28, insert_en stays 0.
//  5 rob_redirect, target 0x100, in WAIT before ack:
//    -> DRAIN; late ack discarded, dec_valid stays 0, next mem_addr=0x100.
//  6 dec_ready=0 for 5 cycles in HOLD -> dec_* stable, mem_req=0.
//    rdy=0 in WAIT with mem_ack -> ack ignored, state unchanged.
//    pc 0xFFFFFFFC nop -> next addr 0x0.

Source files
------------

// File: rtl/fetch_pc.sv
// ============================================================================
// Module      : fetch_pc
// Description : Fetch-stage PC generator. Fetches one instruction per memory
//               handshake, predecodes B-type/JAL, drives the branch predictor
//               and hands {inst, pc, prediction} to decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [INST_W-1:0] mem_inst,
   output logic              pred_insert_en,
   output logic              pred_mux,
   output logic [ADDR_W-1:0] pred_pc1,
   output logic [ADDR_W-1:0] pred_pc2,
   input  logic              pred_taken,
   input  logic              rob_redirect,
   input  logic [ADDR_W-1:0] rob_target,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [INST_W-1:0] dec_inst,
   output logic [ADDR_W-1:0] dec_pc,
   output logic              dec_pred_taken,
   output logic [ADDR_W-1:0] dec_pred_target
);

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [6:0]        c_op_branch = 7'b1100011;
   localparam logic [6:0]        c_op_jal    = 7'b1101111;
   localparam logic [ADDR_W-1:0] c_pc_step   = ADDR_W'(4);

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_stale_addr;
   logic [INST_W-1:0] r_dec_inst;
   logic [ADDR_W-1:0] r_dec_pc;
   logic              r_dec_pred_taken;
   logic [ADDR_W-1:0] r_dec_pred_target;

   logic              w_is_branch;
   logic              w_is_jal;
   logic [ADDR_W-1:0] w_imm_b;
   logic [ADDR_W-1:0] w_imm_j;
   logic [ADDR_W-1:0] w_next_pc;
   logic              w_next_taken;
   logic              w_accept;
   logic              w_outstanding;

   // Predecode of the instruction arriving on the memory bus
   assign w_is_branch = (mem_inst[6:0] == c_op_branch);
   assign w_is_jal    = (mem_inst[6:0] == c_op_jal);
   assign w_imm_b     = {{(ADDR_W-12){mem_inst[31]}}, mem_inst[7], mem_inst[30:25],
                         mem_inst[11:8], 1'b0};
   assign w_imm_j     = {{(ADDR_W-20){mem_inst[31]}}, mem_inst[19:12], mem_inst[20],
                         mem_inst[30:21], 1'b0};

   always_comb begin
      w_next_pc    = r_pc + c_pc_step;
      w_next_taken = 1'b0;
      if (w_is_jal) begin
         w_next_pc    = r_pc + w_imm_j;
         w_next_taken = 1'b1;
      end else if (w_is_branch && pred_taken) begin
         w_next_pc    = r_pc + w_imm_b;
         w_next_taken = 1'b1;
      end
   end

   assign w_accept      = (r_state == S_WAIT) && mem_ack && !rob_redirect;
   // A request is on the bus in REQ/WAIT; without an ack it must be drained.
   assign w_outstanding = ((r_state == S_REQ) || (r_state == S_WAIT)) && !mem_ack;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_REQ;
      end else if (rdy) begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      if (rob_redirect) begin
         if (w_outstanding || ((r_state == S_DRAIN) && !mem_ack)) begin
            w_next_state = S_DRAIN;
         end else begin
            w_next_state = S_REQ;
         end
      end else begin
         case (r_state)
            S_REQ:   w_next_state = S_WAIT;
            S_WAIT:  if (mem_ack)   w_next_state = S_HOLD;
            S_HOLD:  if (dec_ready) w_next_state = S_REQ;
            S_DRAIN: if (mem_ack)   w_next_state = S_REQ;
            default: w_next_state = S_REQ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc              <= RESET_PC;
         r_stale_addr      <= '0;
         r_dec_inst        <= '0;
         r_dec_pc          <= '0;
         r_dec_pred_taken  <= 1'b0;
         r_dec_pred_target <= '0;
      end else if (rdy) begin
         if (rob_redirect) begin
            r_pc <= rob_target;
            if (w_outstanding) begin
               r_stale_addr <= r_pc;
            end
         end else if (w_accept) begin
            r_dec_inst        <= mem_inst;
            r_dec_pc          <= r_pc;
            r_dec_pred_taken  <= w_next_taken;
            r_dec_pred_target <= w_next_pc;
         end else if ((r_state == S_HOLD) && dec_ready) begin
            r_pc <= r_dec_pred_target;
         end
      end
   end

   // Outputs; the request is masked while reset is held
   always_comb begin
      mem_req        = rst && (r_state != S_HOLD);
      mem_addr       = (r_state == S_DRAIN) ? r_stale_addr : r_pc;
      pred_insert_en = rst && rdy && w_accept && w_is_branch;
      pred_mux       = 1'b0;
      pred_pc1       = r_pc;
      pred_pc2       = r_pc;
      dec_valid      = (r_state == S_HOLD);
   end

   assign dec_inst        = r_dec_inst;
   assign dec_pc          = r_dec_pc;
   assign dec_pred_taken  = r_dec_pred_taken;
   assign dec_pred_target = r_dec_pred_target;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc.sv
// ============================================================================
// Module      : tb_fetch_pc
// Description : Directed self-checking bench for fetch_pc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_inst = '0;
   logic        pred_insert_en;
   logic        pred_mux;
   logic [31:0] pred_pc1;
   logic [31:0] pred_pc2;
   logic        pred_taken = 1'b0;
   logic        rob_redirect = 1'b0;
   logic [31:0] rob_target = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        dec_pred_taken;
   logic [31:0] dec_pred_target;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_pc #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_inst        (mem_inst),
      .pred_insert_en  (pred_insert_en),
      .pred_mux        (pred_mux),
      .pred_pc1        (pred_pc1),
      .pred_pc2        (pred_pc2),
      .pred_taken      (pred_taken),
      .rob_redirect    (rob_redirect),
      .rob_target      (rob_target),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_inst        (dec_inst),
      .dec_pc          (dec_pc),
      .dec_pred_taken  (dec_pred_taken),
      .dec_pred_target (dec_pred_target)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an ack in WAIT, check predictor handshake, land in HOLD
   task automatic fetch(input logic [31:0] inst, input logic taken,
                        input logic exp_ins, input logic [31:0] pc);
      mem_ack    = 1'b1;
      mem_inst   = inst;
      pred_taken = taken;
      #1;
      chk("insert_en_ack", pred_insert_en, exp_ins);
      chk("pred_pc1", pred_pc1, pc);
      tick();
      mem_ack    = 1'b0;
      pred_taken = 1'b0;
      #1;
      chk("insert_en_after", pred_insert_en, 1'b0);
      chk("dec_valid_hold", dec_valid, 1'b1);
      chk("dec_pc", dec_pc, pc);
      chk("mem_req_hold", mem_req, 1'b0);
   endtask

   // Decode handshake, then check the next fetch address in REQ
   task automatic handshake(input logic [31:0] next_addr);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      #1;
      chk("dec_valid_req", dec_valid, 1'b0);
      chk("mem_req_req", mem_req, 1'b1);
      chk("next_addr", mem_addr, next_addr);
      tick();
   endtask

   // Redirect from HOLD goes straight to REQ at the target
   task automatic redirect_from_hold(input logic [31:0] tgt);
      rob_redirect = 1'b1;
      rob_target   = tgt;
      tick();
      rob_redirect = 1'b0;
      #1;
      chk("redir_dec_valid", dec_valid, 1'b0);
      chk("redir_addr", mem_addr, tgt);
      tick();
   endtask

   logic [31:0] held_inst;

   initial begin
      // Reset
      rst = 1'b0;
      tick();
      tick();
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_insert_en", pred_insert_en, 1'b0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_taken", dec_pred_taken, 1'b0);
      chk("pred_mux", pred_mux, 1'b0);
      rst = 1'b1;
      tick();
      chk("rel_mem_req", mem_req, 1'b1);
      chk("rel_mem_addr", mem_addr, 32'h0);

      // Sequential nop at 0x0
      fetch(32'h00000013, 1'b0, 1'b0, 32'h0);
      chk("nop_target", dec_pred_target, 32'h4);
      chk("nop_taken", dec_pred_taken, 1'b0);
      chk("nop_inst", dec_inst, 32'h00000013);
      handshake(32'h4);

      // Nop at 0x4, redirect to 0x10 from HOLD
      fetch(32'h00000013, 1'b0, 1'b0, 32'h4);
      redirect_from_hold(32'h10);

      // beq +8 taken at 0x10
      fetch(32'h00000463, 1'b1, 1'b1, 32'h10);
      chk("beq_t_target", dec_pred_target, 32'h18);
      chk("beq_t_taken", dec_pred_taken, 1'b1);
      handshake(32'h18);

      // beq +8 not taken at 0x18
      fetch(32'h00000463, 1'b0, 1'b1, 32'h18);
      chk("beq_nt_target", dec_pred_target, 32'h1C);
      chk("beq_nt_taken", dec_pred_taken, 1'b0);
      handshake(32'h1C);

      // JALR is not predecoded as a jump
      fetch(32'h00008067, 1'b1, 1'b0, 32'h1C);
      chk("jalr_target", dec_pred_target, 32'h20);
      chk("jalr_taken", dec_pred_taken, 1'b0);
      handshake(32'h20);

      // JAL +8 at 0x20, then decode stall for 5 cycles
      fetch(32'h0080006F, 1'b0, 1'b0, 32'h20);
      chk("jal_taken", dec_pred_taken, 1'b1);
      chk("jal_target", dec_pred_target, 32'h28);
      held_inst = dec_inst;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", dec_valid, 1'b1);
         chk("stall_mem_req", mem_req, 1'b0);
         chk("stall_pc", dec_pc, 32'h20);
         chk("stall_inst", dec_inst, held_inst);
         chk("stall_target", dec_pred_target, 32'h28);
      end
      handshake(32'h28);

      // rdy=0 in WAIT: ack ignored, state frozen
      rdy      = 1'b0;
      mem_ack  = 1'b1;
      mem_inst = 32'h00000463;
      pred_taken = 1'b1;
      #1;
      chk("rdy0_insert_en", pred_insert_en, 1'b0);
      tick();
      tick();
      mem_ack    = 1'b0;
      pred_taken = 1'b0;
      rdy        = 1'b1;
      #1;
      chk("rdy0_dec_valid", dec_valid, 1'b0);
      chk("rdy0_mem_req", mem_req, 1'b1);
      chk("rdy0_mem_addr", mem_addr, 32'h28);
      chk("rdy0_dec_pc", dec_pc, 32'h20);

      // Redirect in WAIT before ack -> DRAIN on stale address
      rob_redirect = 1'b1;
      rob_target   = 32'h100;
      mem_inst     = 32'h00000463;
      #1;
      chk("redir_insert_en", pred_insert_en, 1'b0);
      tick();
      rob_redirect = 1'b0;
      #1;
      chk("drain_mem_req", mem_req, 1'b1);
      chk("drain_addr", mem_addr, 32'h28);
      tick();
      chk("drain_wait_addr", mem_addr, 32'h28);
      mem_ack  = 1'b1;
      mem_inst = 32'h00000013;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("drain_dec_valid", dec_valid, 1'b0);
      chk("drain_dec_pc", dec_pc, 32'h20);
      chk("drain_next_addr", mem_addr, 32'h100);
      chk("drain_next_req", mem_req, 1'b1);
      tick();

      // Nop at 0x100, redirect to the top of the address space, wrap to 0
      fetch(32'h00000013, 1'b0, 1'b0, 32'h100);
      redirect_from_hold(32'hFFFF_FFFC);
      fetch(32'h00000013, 1'b0, 1'b0, 32'hFFFF_FFFC);
      chk("wrap_target", dec_pred_target, 32'h0);
      handshake(32'h0);

      // Backward taken branch at 0x0: beq -4 wraps to 0xFFFFFFFC
      fetch(32'hFE000EE3, 1'b1, 1'b1, 32'h0);
      chk("bneg_target", dec_pred_target, 32'hFFFF_FFFC);
      chk("bneg_taken", dec_pred_taken, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
